timer_tick_ctrl: RTL and testbench
==================================

Name: timer_tick_ctrl

Overview:
Source end of the LED blink interface. Generates the free-running divided square-wave clock `divided_clk` and the blink `enable` that the LED blinker consumes. Runs a programmable countdown in whole ticks. On expiry, asserts the blink enable for a fixed number of ticks, then returns to idle. Sits between the top-level button/switch logic and the LED blinker.

Parameters:
- CLK_HZ, 50_000_000: input clock frequency in Hz.
- TICK_HZ, 1: tick / `divided_clk` frequency. PERIOD = CLK_HZ/TICK_HZ must be even and >= 2.
- CNT_W, 16: width of the countdown value.
- ALARM_TICKS, 10: number of ticks `blink_en` stays high after expiry (>= 1).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle request; loads `load_value` and starts the countdown.
- `stop`, in, 1: single-cycle abort; returns to IDLE.
- `load_value`, in, CNT_W: countdown length in ticks, sampled on an accepted `start`.
- `divided_clk`, out, 1: 50% duty square wave at TICK_HZ; drives the blinker clock.
- `tick`, out, 1: one-`clk` strobe per tick period.
- `blink_en`, out, 1: high in ALARM; drives the blinker enable.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-`clk` pulse on expiry.
- `remaining`, out, CNT_W: ticks left in the countdown.

Behaviour:
- Reset values (async, while `rst`=1): state IDLE, prescaler count 0, `divided_clk`=0, `tick`=0, `blink_en`=0, `busy`=0, `done`=0, `remaining`=0, alarm count 0. All outputs are registered.
- Prescaler:
  - `pre_cnt` counts 0..PERIOD-1 and wraps.
  - `divided_clk` is low while `pre_cnt` < PERIOD/2 and high otherwise, registered.
  - `tick` is high for the single cycle after `pre_cnt` = PERIOD-1. This coincides with the falling edge of `divided_clk`.
  - First `tick` arrives PERIOD cycles after reset release.
  - An accepted `start` synchronously clears `pre_cnt` to 0 and drives `divided_clk` low. The first countdown tick is therefore exactly PERIOD cycles after `start`.
- Priority: `stop` beats `start` beats `tick`, in every state.
- IDLE:
  - `start` with `load_value` != 0: `remaining`=`load_value`, go to RUN.
  - `start` with `load_value` = 0: go directly to ALARM, pulse `done`, `remaining`=0.
  - `stop`: no effect.
- RUN (`busy`=1):
  - On `tick`, `remaining` decrements by 1.
  - On `tick` with `remaining`=1: `remaining`=0, pulse `done`, go to ALARM, clear alarm count.
  - `stop`: go to IDLE, `remaining`=0, no `done`.
  - `start`: restart from the new `load_value`, with the same rules as IDLE.
  - `tick` and `stop` in the same cycle: IDLE, no decrement.
- ALARM (`blink_en`=1):
  - Each `tick` increments the alarm count. On the ALARM_TICKS-th tick, go to IDLE and drop `blink_en`.
  - `stop`: go to IDLE.
  - `start`: reload per the IDLE rules.
- Output timing: `busy` and `blink_en` reflect the state registered in the same edge as the transition. `done` is high for exactly one cycle.
- Width rules:
  - `remaining` never underflows.
  - `load_value` = 2^CNT_W - 1 is legal.
  - Alarm count width is clog2(ALARM_TICKS+1).
- `divided_clk` keeps running in all states, so the blinker's output register stays clocked when `blink_en` falls and the LED clears to 0 on its next edge.
- Reset mid-operation: immediate return to the reset values regardless of state.

Decomposition:
- Shared header `timer_defs.vh`: state encodings (IDLE=2'd0, RUN=2'd1, ALARM=2'd2) and PERIOD/half-period derivation macros, shared with other timer blocks.
- One natural sub-module, `tick_prescaler`:
  - Parameters: CLK_HZ, TICK_HZ.
  - Ports: `clk`, `rst`, `restart` in; `divided_clk`, `tick` out.
- The FSM and countdown stay in the top module.

Test Plan:
All scenarios use CLK_HZ=8, TICK_HZ=1 (PERIOD=8), CNT_W=8, ALARM_TICKS=3.
1. Release `rst`, idle for 40 cycles. Required: `divided_clk` low 4 / high 4 repeating; `tick` pulses at cycles 8, 16, 24, 32; `blink_en`=`busy`=`done`=0.
2. `start` with `load_value`=3. Required:
   - `busy`=1 next cycle.
   - `remaining` reads 3, 2, 1, 0 at ticks 8, 16, 24 cycles after `start`.
   - `done` pulses once with the third tick, then `blink_en`=1 for 3 ticks (24 cycles), then IDLE.
3. `start` with `load_value`=0. Required: `done` pulse and `blink_en`=1 on the next edge, with no RUN cycle.
4. `start` with `load_value`=5, then `stop` asserted in the same cycle as the 2nd tick. Required: `remaining` → 0, not 3; IDLE; no `done`; `blink_en` never asserted.
5. In ALARM after 1 tick, assert `start` with `load_value`=2. Required: `blink_en` drops, `busy`=1, `remaining`=2, prescaler restarted (next tick 8 cycles later).
6. Assert `rst` mid-RUN with `remaining`=4. Required: all outputs go to 0 asynchronously (before the next `clk` edge); after release, IDLE, and the first `tick` arrives 8 cycles later.

Source files
------------

// File: rtl/timer_tick_ctrl_pkg.sv
// Shared definitions for the timer blocks: state encodings and prescaler
// period derivation.
package timer_tick_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ALARM = 2'd2;

  function automatic int unsigned period_of(input int unsigned clk_hz,
                                            input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int unsigned half_period_of(input int unsigned clk_hz,
                                                 input int unsigned tick_hz);
    return period_of(clk_hz, tick_hz) / 2;
  endfunction

endpackage

// File: rtl/timer_tick_ctrl_tick_prescaler.sv
// Free-running clock divider: 50% duty divided_clk plus a one-cycle tick
// strobe coinciding with each falling edge of divided_clk.
module tick_prescaler
  import timer_tick_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic divided_clk,
  output logic tick
);

  localparam int unsigned PERIOD = period_of(CLK_HZ, TICK_HZ);
  localparam int unsigned HALF   = half_period_of(CLK_HZ, TICK_HZ);
  localparam int unsigned PRE_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    tick_d    = 1'b0;
    if (restart) begin
      pre_cnt_d = '0;
    end else if (pre_cnt_q == PRE_W'(PERIOD - 1)) begin
      pre_cnt_d = '0;
      tick_d    = 1'b1;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
    // Decoded from the next count so the falling edge lines up with tick.
    div_d = (pre_cnt_d >= PRE_W'(HALF));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      div_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
    end
  end

  assign divided_clk = div_q;
  assign tick        = tick_q;

endmodule

// File: rtl/timer_tick_ctrl.sv
// Countdown timer in whole ticks; on expiry raises blink_en for ALARM_TICKS
// ticks to drive the LED blinker, which is clocked by divided_clk.
module timer_tick_ctrl
  import timer_tick_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] load_value,
  output logic             divided_clk,
  output logic             tick,
  output logic             blink_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  localparam int unsigned ALARM_W = $clog2(ALARM_TICKS + 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [ALARM_W-1:0] alarm_q, alarm_d;
  logic               done_q, done_d;
  logic               busy_q, blink_q;
  logic               restart;

  assign restart = start & ~stop;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .divided_clk(divided_clk),
    .tick       (tick)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    alarm_d = alarm_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else if (start) begin
      alarm_d = '0;
      if (load_value != '0) begin
        state_d = ST_RUN;
        rem_d   = load_value;
      end else begin
        state_d = ST_ALARM;
        rem_d   = '0;
        done_d  = 1'b1;
      end
    end else if (tick) begin
      case (state_q)
        ST_RUN: begin
          if (rem_q == CNT_W'(1)) begin
            rem_d   = '0;
            done_d  = 1'b1;
            state_d = ST_ALARM;
            alarm_d = '0;
          end else if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
          end
        end
        ST_ALARM: begin
          if (alarm_q == ALARM_W'(ALARM_TICKS - 1)) begin
            state_d = ST_IDLE;
            alarm_d = '0;
          end else begin
            alarm_d = alarm_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      alarm_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      alarm_q <= alarm_d;
      done_q  <= done_d;
      busy_q  <= (state_d == ST_RUN);
      blink_q <= (state_d == ST_ALARM);
    end
  end

  assign busy      = busy_q;
  assign blink_en  = blink_q;
  assign done      = done_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_timer_tick_ctrl.sv
// Directed bench for timer_tick_ctrl with PERIOD=8, CNT_W=8, ALARM_TICKS=3.
module tb_timer_tick_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] load_value = '0;
  logic       divided_clk, tick, blink_en, busy, done;
  logic [7:0] remaining;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen  = 0;
  int blink_seen = 0;
  int d0, b0;

  timer_tick_ctrl #(
    .CLK_HZ     (8),
    .TICK_HZ    (1),
    .CNT_W      (8),
    .ALARM_TICKS(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .load_value (load_value),
    .divided_clk(divided_clk),
    .tick       (tick),
    .blink_en   (blink_en),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)     done_seen++;
    if (blink_en) blink_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0d exp %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start sampled on the next edge; returns 1ns after that edge.
  task automatic do_start(input logic [7:0] v);
    start = 1'b1;
    load_value = v;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    // 1: free-running prescaler after reset
    step(2);
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      check("t1_div", divided_clk, ((k % 8) >= 4) ? 1 : 0);
      check("t1_tick", tick, ((k % 8) == 0) ? 1 : 0);
      check("t1_idle", {blink_en, busy, done}, 0);
    end

    // 2: countdown of 3
    d0 = done_seen;
    do_start(8'd3);
    check("t2_busy", busy, 1);
    check("t2_rem3", remaining, 3);
    step(8);
    check("t2_tick1", tick, 1);
    check("t2_rem3b", remaining, 3);
    step(1);
    check("t2_rem2", remaining, 2);
    step(8);
    check("t2_rem1", remaining, 1);
    step(8);
    check("t2_rem0", remaining, 0);
    check("t2_done", done, 1);
    check("t2_blink", blink_en, 1);
    check("t2_busy0", busy, 0);
    step(1);
    check("t2_done_low", done, 0);
    step(22);
    check("t2_blink_end", blink_en, 1);
    step(1);
    check("t2_blink_off", blink_en, 0);
    check("t2_busy_off", busy, 0);
    check("t2_done_cnt", done_seen - d0, 1);

    // 3: zero load goes straight to ALARM
    do_start(8'd0);
    check("t3_done", done, 1);
    check("t3_blink", blink_en, 1);
    check("t3_busy", busy, 0);
    check("t3_rem", remaining, 0);
    step(30);
    check("t3_idle", blink_en, 0);

    // 4: stop coinciding with the 2nd tick
    d0 = done_seen;
    b0 = blink_seen;
    do_start(8'd5);
    step(9);
    check("t4_rem4", remaining, 4);
    step(7);
    check("t4_tick2", tick, 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("t4_rem0", remaining, 0);
    check("t4_busy", busy, 0);
    step(40);
    check("t4_no_done", done_seen - d0, 0);
    check("t4_no_blink", blink_seen - b0, 0);

    // 5: restart from ALARM after one tick
    do_start(8'd0);
    step(8);
    check("t5_tick", tick, 1);
    step(2);
    check("t5_blink", blink_en, 1);
    do_start(8'd2);
    check("t5_blink_off", blink_en, 0);
    check("t5_busy", busy, 1);
    check("t5_rem", remaining, 2);
    step(7);
    check("t5_tick_early", tick, 0);
    step(1);
    check("t5_tick_8", tick, 1);
    step(1);
    check("t5_rem1", remaining, 1);

    // 6: async reset mid-RUN
    do_start(8'd5);
    step(9);
    check("t6_rem4", remaining, 4);
    #2 rst = 1'b1;
    #1;
    check("t6_async", {divided_clk, tick, blink_en, busy, done}, 0);
    check("t6_rem", remaining, 0);
    #2 rst = 1'b0;
    step(7);
    check("t6_tick_early", tick, 0);
    step(1);
    check("t6_tick_8", tick, 1);
    check("t6_idle", {busy, blink_en}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
